// File: rtl/grid_player_mover.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | grid_player_mover : tile-locked player motion, death/respawn, walk anim   |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module grid_player_mover #(
  parameter int BOARD_X0       = 32,
  parameter int BOARD_Y0       = 160,
  parameter int TILE           = 32,
  parameter int COLS           = 15,
  parameter int ROWS           = 10,
  parameter int START_COL      = 7,
  parameter int START_ROW      = 9,
  parameter int STEP           = 2,
  parameter int ANIM_FRAMES    = 3,
  parameter int ANIM_DIV       = 4,
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        leftArrowPressed,
  input  logic        rightArrowPressed,
  input  logic        upArrowPressed,
  input  logic        downArrowPressed,
  input  logic        player_died,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  player_direction,
  output logic [2:0]  image,
  output logic        player_awake,
  output logic        moving
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_MOVE  = 2'd1;
  localparam logic [1:0] c_DYING = 2'd2;

  localparam logic [1:0] c_RIGHT = 2'd0;
  localparam logic [1:0] c_LEFT  = 2'd1;
  localparam logic [1:0] c_UP    = 2'd2;
  localparam logic [1:0] c_DOWN  = 2'd3;

  localparam int c_LOG_TILE = $clog2(TILE);
  localparam int c_AW       = $clog2(ANIM_DIV + 1);
  localparam int c_DW       = $clog2(RESPAWN_FRAMES + 1);

  localparam logic [10:0] c_X0       = 11'(BOARD_X0);
  localparam logic [10:0] c_Y0       = 11'(BOARD_Y0);
  localparam logic [10:0] c_SPAWN_X  = 11'(BOARD_X0 + START_COL * TILE);
  localparam logic [10:0] c_SPAWN_Y  = 11'(BOARD_Y0 + START_ROW * TILE);
  localparam logic [10:0] c_TMASK    = 11'(TILE - 1);
  localparam logic [10:0] c_STEP     = 11'(STEP);
  localparam logic [10:0] c_LAST_COL = 11'(COLS - 1);
  localparam logic [10:0] c_LAST_ROW = 11'(ROWS - 1);

  localparam logic [2:0]      c_DEATH_IMG  = 3'd7;
  localparam logic [2:0]      c_LAST_IMG   = 3'(ANIM_FRAMES - 1);
  localparam logic [c_AW-1:0] c_LAST_ANIM  = c_AW'(ANIM_DIV - 1);
  localparam logic [c_DW-1:0] c_LAST_DEATH = c_DW'(RESPAWN_FRAMES - 1);

  logic [1:0]      state_q, state_d;
  logic [10:0]     x_q, x_d, y_q, y_d;
  logic [1:0]      dir_q, dir_d;
  logic [2:0]      image_q, image_d;
  logic [c_AW-1:0] anim_q, anim_d;
  logic [c_DW-1:0] death_q, death_d;
  logic            pend_vld_q, pend_vld_d;
  logic [1:0]      pend_dir_q, pend_dir_d;
  logic            died_q, died_d;

  logic [10:0] w_offx, w_offy, w_col, w_row;
  logic        w_aligned;
  logic [3:0]  w_can;
  logic        w_req_vld;
  logic [1:0]  w_req_dir;
  logic        w_step;
  logic [1:0]  w_nd;

  assign w_offx    = x_q - c_X0;
  assign w_offy    = y_q - c_Y0;
  assign w_col     = w_offx >> c_LOG_TILE;
  assign w_row     = w_offy >> c_LOG_TILE;
  assign w_aligned = ((w_offx | w_offy) & c_TMASK) == 11'd0;

  // Only meaningful while aligned: can the neighbouring tile in direction d be entered.
  assign w_can[c_RIGHT] = (w_col != c_LAST_COL);
  assign w_can[c_LEFT]  = (w_col != 11'd0);
  assign w_can[c_UP]    = (w_row != 11'd0);
  assign w_can[c_DOWN]  = (w_row != c_LAST_ROW);

  assign w_req_vld = upArrowPressed | downArrowPressed | leftArrowPressed | rightArrowPressed;
  assign w_req_dir = upArrowPressed   ? c_UP   :
                     downArrowPressed ? c_DOWN :
                     leftArrowPressed ? c_LEFT : c_RIGHT;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    image_d    = image_q;
    anim_d     = anim_q;
    death_d    = death_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    died_d     = died_q | player_died;
    w_step     = 1'b0;
    w_nd       = dir_q;

    if (startOfFrame) begin
      died_d = player_died;
      if (state_q == c_DYING) begin
        if (death_q == c_LAST_DEATH) begin
          state_d    = c_IDLE;
          x_d        = c_SPAWN_X;
          y_d        = c_SPAWN_Y;
          dir_d      = c_RIGHT;
          image_d    = 3'd0;
          anim_d     = '0;
          death_d    = '0;
          pend_vld_d = 1'b0;
        end else begin
          death_d = death_q + 1'b1;
        end
      end else if (died_q) begin
        state_d    = c_DYING;
        image_d    = c_DEATH_IMG;
        death_d    = '0;
        pend_vld_d = 1'b0;
      end else if (state_q == c_IDLE) begin
        if (w_req_vld) begin
          dir_d = w_req_dir;
          if (w_can[w_req_dir]) begin
            state_d = c_MOVE;
            w_nd    = w_req_dir;
            w_step  = 1'b1;
          end
        end
      end else begin
        if (w_req_vld) begin
          pend_vld_d = 1'b1;
          pend_dir_d = w_req_dir;
        end else if (w_aligned) begin
          pend_vld_d = 1'b0;
        end

        if (!w_aligned) begin
          // Mid-tile only a reversal (flip of bit 0) may change the heading.
          if (w_req_vld && (w_req_dir == (dir_q ^ 2'b01))) begin
            w_nd = w_req_dir;
          end
          dir_d  = w_nd;
          w_step = 1'b1;
        end else if (pend_vld_d) begin
          w_nd       = pend_dir_d;
          dir_d      = w_nd;
          pend_vld_d = 1'b0;
          if (w_can[w_nd]) begin
            w_step = 1'b1;
          end else begin
            state_d = c_IDLE;
          end
        end else begin
          state_d = c_IDLE;
        end
      end
    end

    if (w_step) begin
      case (w_nd)
        c_RIGHT: x_d = x_q + c_STEP;
        c_LEFT:  x_d = x_q - c_STEP;
        c_UP:    y_d = y_q - c_STEP;
        default: y_d = y_q + c_STEP;
      endcase
      if (anim_q == c_LAST_ANIM) begin
        anim_d  = '0;
        image_d = (image_q == c_LAST_IMG) ? 3'd0 : image_q + 3'd1;
      end else begin
        anim_d = anim_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= c_IDLE;
      x_q        <= c_SPAWN_X;
      y_q        <= c_SPAWN_Y;
      dir_q      <= c_RIGHT;
      image_q    <= 3'd0;
      anim_q     <= '0;
      death_q    <= '0;
      pend_vld_q <= 1'b0;
      pend_dir_q <= c_RIGHT;
      died_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      image_q    <= image_d;
      anim_q     <= anim_d;
      death_q    <= death_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      died_q     <= died_d;
    end
  end

  assign topLeftX         = x_q;
  assign topLeftY         = y_q;
  assign player_direction = dir_q;
  assign image            = image_q;
  assign player_awake     = (state_q != c_DYING);
  assign moving           = (state_q == c_MOVE);

endmodule
`default_nettype wire

// File: tb/tb_grid_player_mover.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_grid_player_mover : randomized + directed bench with behavioural model |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_grid_player_mover;

  localparam int X0 = 32, Y0 = 160, TILE = 32, COLS = 15, ROWS = 10;
  localparam int SCOL = 7, SROW = 9, STEP = 2, AFR = 3, ADIV = 4, RESP = 120;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sof = 1'b0;
  logic        lf = 1'b0, rt = 1'b0, up = 1'b0, dn = 1'b0;
  logic        died = 1'b0;
  logic [10:0] tlx, tly;
  logic [1:0]  pdir;
  logic [2:0]  img;
  logic        awake, mov;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pixel offsets from board origin, mode 0=idle 1=move 2=dying
  int m_px, m_py, m_dir, m_mode, m_img, m_anim, m_dcnt;
  bit m_died;

  grid_player_mover dut (
    .clk               (clk),
    .reset             (reset),
    .startOfFrame      (sof),
    .leftArrowPressed  (lf),
    .rightArrowPressed (rt),
    .upArrowPressed    (up),
    .downArrowPressed  (dn),
    .player_died       (died),
    .topLeftX          (tlx),
    .topLeftY          (tly),
    .player_direction  (pdir),
    .image             (img),
    .player_awake      (awake),
    .moving            (mov)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int dx(input int d);
    return (d == 0) ? 1 : (d == 1) ? -1 : 0;
  endfunction

  function automatic int dy(input int d);
    return (d == 3) ? 1 : (d == 2) ? -1 : 0;
  endfunction

  function automatic int opposite(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 3 : 2;
  endfunction

  function automatic int cur_req();
    if (up) return 2;
    if (dn) return 3;
    if (lf) return 0 + 1;
    if (rt) return 0;
    return -1;
  endfunction

  function automatic bit on_board(input int d);
    int nc, nr;
    nc = m_px / TILE + dx(d);
    nr = m_py / TILE + dy(d);
    return (nc >= 0) && (nc < COLS) && (nr >= 0) && (nr < ROWS);
  endfunction

  task automatic model_reset();
    m_px = SCOL * TILE; m_py = SROW * TILE;
    m_dir = 0; m_mode = 0; m_img = 0; m_anim = 0; m_dcnt = 0; m_died = 0;
  endtask

  task automatic model_step(input int d);
    m_px += dx(d) * STEP;
    m_py += dy(d) * STEP;
    m_anim++;
    if (m_anim == ADIV) begin
      m_anim = 0;
      m_img  = (m_img + 1) % AFR;
    end
  endtask

  task automatic model_sof();
    int r;
    bit al;
    r  = cur_req();
    al = (m_px % TILE == 0) && (m_py % TILE == 0);
    if (m_mode == 2) begin
      m_dcnt++;
      if (m_dcnt == RESP) model_reset();
    end else if (m_died) begin
      m_mode = 2; m_img = 7; m_dcnt = 0;
    end else if (m_mode == 0) begin
      if (r >= 0) begin
        m_dir = r;
        if (on_board(r)) begin
          m_mode = 1;
          model_step(r);
        end
      end
    end else if (!al) begin
      if (r >= 0 && r == opposite(m_dir)) m_dir = r;
      model_step(m_dir);
    end else if (r < 0) begin
      m_mode = 0;
    end else begin
      m_dir = r;
      if (on_board(r)) model_step(r);
      else m_mode = 0;
    end
    m_died = 0;
  endtask

  task automatic compare_all();
    check("X", int'(tlx), X0 + m_px);
    check("Y", int'(tly), Y0 + m_py);
    check("dir", int'(pdir), m_dir);
    check("image", int'(img), m_img);
    check("awake", int'(awake), (m_mode != 2) ? 1 : 0);
    check("moving", int'(mov), (m_mode == 1) ? 1 : 0);
  endtask

  // One frame: SOF high across one rising edge, then compare, then a spare cycle.
  task automatic frame();
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    model_sof();
    compare_all();
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_died();
    died = 1'b1;
    @(negedge clk);
    died = 1'b0;
    m_died = 1;
  endtask

  task automatic keys(input bit u, input bit d, input bit l, input bit r);
    up = u; dn = d; lf = l; rt = r;
  endtask

  // Asynchronous reset between edges; state must change before the next clock.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_X", int'(tlx), 256);
    check("rst_Y", int'(tly), 448);
    check("rst_dir", int'(pdir), 0);
    check("rst_image", int'(img), 0);
    check("rst_awake", int'(awake), 1);
    check("rst_moving", int'(mov), 0);
    keys(0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compare_all();

    // Reset asserted mid-move
    keys(0, 0, 0, 1);
    frames(5);
    check("premove_moving", int'(mov), 1);
    do_reset();

    // Right 16 frames reaches the next tile, release stops there
    keys(0, 0, 0, 1);
    frames(16);
    check("t2_X", int'(tlx), 288);
    keys(0, 0, 0, 0);
    frame();
    check("t2_X_idle", int'(tlx), 288);
    check("t2_moving", int'(mov), 0);

    // Perpendicular request mid-tile waits for alignment
    do_reset();
    keys(0, 0, 0, 1);
    frames(5);
    check("t3_X266", int'(tlx), 266);
    keys(1, 0, 0, 1);
    frames(11);
    check("t3_X288", int'(tlx), 288);
    check("t3_dir_right", int'(pdir), 0);
    frame();
    check("t3_dir_up", int'(pdir), 2);
    check("t3_Y446", int'(tly), 446);
    frame();
    check("t3_Y444", int'(tly), 444);

    // Edge blocking: bottom row and left column
    do_reset();
    keys(0, 1, 0, 0);
    frame();
    check("t4_dir_down", int'(pdir), 3);
    check("t4_Y448", int'(tly), 448);
    check("t4_moving", int'(mov), 0);
    keys(0, 0, 1, 0);
    frames(113);
    check("t4_X32", int'(tlx), 32);
    frame();
    check("t4_X32_hold", int'(tlx), 32);
    check("t4_left_moving", int'(mov), 0);

    // Death mid-move and respawn
    do_reset();
    keys(0, 0, 0, 1);
    frames(3);
    pulse_died();
    frame();
    check("t5_awake", int'(awake), 0);
    check("t5_image", int'(img), 7);
    check("t5_X_frozen", int'(tlx), 262);
    frames(RESP - 1);
    check("t5_still_dying", int'(awake), 0);
    frame();
    check("t5_spawn_X", int'(tlx), 256);
    check("t5_spawn_awake", int'(awake), 1);
    check("t5_spawn_image", int'(img), 0);

    // Walk animation and immediate reversal
    do_reset();
    keys(0, 0, 0, 1);
    frames(4);
    check("t6_img1", int'(img), 1);
    frames(4);
    check("t6_img2", int'(img), 2);
    frames(4);
    check("t6_img0", int'(img), 0);
    do_reset();
    keys(0, 0, 0, 1);
    frames(3);
    check("t6_X262", int'(tlx), 262);
    keys(0, 0, 1, 0);
    frame();
    check("t6_rev_dir", int'(pdir), 1);
    check("t6_rev_X", int'(tlx), 260);

    // Randomized key sequences with occasional deaths
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 7))
          0: keys(0, 0, 0, 0);
          1: keys(1, 0, 0, 0);
          2: keys(0, 1, 0, 0);
          3: keys(0, 0, 1, 0);
          4: keys(0, 0, 0, 1);
          default: keys(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        endcase
      end
      if ($urandom_range(0, 199) == 0) pulse_died();
      frame();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
